// File: rtl/icache_pkg.sv
`default_nettype none
// ============================================================================
// Module      : icache_pkg
// Description : Shared constants and FSM state encoding for the instruction
//               cache (index/tag widths, IDLE/REQ/WAIT states).
// Revision    : 1.0  initial release
// ============================================================================
package icache_pkg;

    localparam int c_INDEX_BITS = 6;
    localparam int c_ADDR_WIDTH = 32;
    localparam int c_TAG_BITS   = c_ADDR_WIDTH - c_INDEX_BITS - 2;
    localparam int c_WORD_WIDTH = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_e;

endpackage : icache_pkg
`default_nettype wire

// File: rtl/icache_array.sv
`default_nettype none
// ============================================================================
// Module      : icache_array
// Description : Valid/tag/data storage for a direct-mapped, one-word-per-line
//               cache. Combinational hit lookup, single synchronous write port,
//               valid bits cleared asynchronously on reset.
// Ports       : clk, rst (async, active-low)
//               i_rd_index/i_rd_tag -> o_hit, o_rd_data   (lookup)
//               i_wr_en/i_wr_index/i_wr_tag/i_wr_data     (fill)
// Revision    : 1.0  initial release
// ============================================================================
module icache_array
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = c_INDEX_BITS,
    parameter int TAG_BITS   = c_TAG_BITS,
    parameter int DATA_WIDTH = c_WORD_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] i_rd_index,
    input  logic [TAG_BITS-1:0]   i_rd_tag,
    output logic                  o_hit,
    output logic [DATA_WIDTH-1:0] o_rd_data,
    input  logic                  i_wr_en,
    input  logic [INDEX_BITS-1:0] i_wr_index,
    input  logic [TAG_BITS-1:0]   i_wr_tag,
    input  logic [DATA_WIDTH-1:0] i_wr_data
);

    localparam int c_DEPTH = 1 << INDEX_BITS;

    logic [c_DEPTH-1:0]    r_valid;
    logic [TAG_BITS-1:0]   r_tag  [c_DEPTH];
    logic [DATA_WIDTH-1:0] r_data [c_DEPTH];

    // Only the valid bits need a reset; tag/data are don't-care while invalid.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_valid <= '0;
        end else if (i_wr_en) begin
            r_valid[i_wr_index] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (i_wr_en) begin
            r_tag[i_wr_index]  <= i_wr_tag;
            r_data[i_wr_index] <= i_wr_data;
        end
    end

    assign o_hit     = r_valid[i_rd_index] && (r_tag[i_rd_index] == i_rd_tag);
    assign o_rd_data = r_data[i_rd_index];

endmodule : icache_array
`default_nettype wire

// File: rtl/icache.sv
`default_nettype none
// ============================================================================
// Module      : icache
// Description : Direct-mapped, one-word-per-line instruction cache between the
//               fetch stage and the memory fetcher (fc). Hits return one cycle
//               after the request; misses issue one request to fc, wait for an
//               instruction completion, fill the line and return the word.
//               A ROB exception aborts an outstanding miss.
// Ports       : clk, rst (async, active-low)
//               fetch side : is_req_from_if, pc_from_if, is_busy_to_if,
//                            is_ready_to_if, instr_to_if, pc_to_if
//               fc side    : is_empty_to_fc, addr_to_fc, is_stall_from_fc,
//                            is_finish_from_fc, is_instr_from_fc, data_from_fc
//               rob side   : is_exception_from_rob
// Options     : ICACHE_PERF_EN adds saturating hit_cnt_out / miss_cnt_out.
// Revision    : 1.0  initial release
// ============================================================================
module icache
    import icache_pkg::*;
#(
    parameter int INDEX_BITS = c_INDEX_BITS,
    parameter int ADDR_WIDTH = c_ADDR_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  is_req_from_if,
    input  logic [ADDR_WIDTH-1:0] pc_from_if,
    output logic                  is_busy_to_if,
    output logic                  is_ready_to_if,
    output logic [31:0]           instr_to_if,
    output logic [ADDR_WIDTH-1:0] pc_to_if,
    output logic                  is_empty_to_fc,
    output logic [ADDR_WIDTH-1:0] addr_to_fc,
    input  logic                  is_stall_from_fc,
    input  logic                  is_finish_from_fc,
    input  logic                  is_instr_from_fc,
    input  logic [31:0]           data_from_fc,
`ifdef ICACHE_PERF_EN
    output logic [31:0]           hit_cnt_out,
    output logic [31:0]           miss_cnt_out,
`endif
    input  logic                  is_exception_from_rob
);

    localparam int c_TAG_W = ADDR_WIDTH - INDEX_BITS - 2;

    state_e                r_state,   w_state_next;
    logic                  r_ready,   w_ready_next;
    logic [31:0]           r_instr,   w_instr_next;
    logic [ADDR_WIDTH-1:0] r_pc,      w_pc_next;
    logic [ADDR_WIDTH-1:0] r_miss_pc, w_miss_pc_next;

    logic                  w_hit;
    logic [31:0]           w_hit_data;
    logic                  w_fill;
    logic                  w_req_fc;
    logic                  w_accept_hit;
    logic                  w_accept_miss;

    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (c_TAG_W),
        .DATA_WIDTH (32)
    ) u_array (
        .clk        (clk),
        .rst        (rst),
        .i_rd_index (pc_from_if[INDEX_BITS+1:2]),
        .i_rd_tag   (pc_from_if[ADDR_WIDTH-1:INDEX_BITS+2]),
        .o_hit      (w_hit),
        .o_rd_data  (w_hit_data),
        .i_wr_en    (w_fill),
        .i_wr_index (r_miss_pc[INDEX_BITS+1:2]),
        .i_wr_tag   (r_miss_pc[ADDR_WIDTH-1:INDEX_BITS+2]),
        .i_wr_data  (data_from_fc)
    );

    // An exception in IDLE suppresses both the hit return and a miss start.
    assign w_accept_hit  = (r_state == IDLE) && is_req_from_if && !is_exception_from_rob && w_hit;
    assign w_accept_miss = (r_state == IDLE) && is_req_from_if && !is_exception_from_rob && !w_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= IDLE;
            r_ready   <= 1'b0;
            r_instr   <= '0;
            r_pc      <= '0;
            r_miss_pc <= '0;
        end else begin
            r_state   <= w_state_next;
            r_ready   <= w_ready_next;
            r_instr   <= w_instr_next;
            r_pc      <= w_pc_next;
            r_miss_pc <= w_miss_pc_next;
        end
    end

    always_comb begin
        w_state_next   = r_state;
        w_ready_next   = 1'b0;
        w_instr_next   = r_instr;
        w_pc_next      = r_pc;
        w_miss_pc_next = r_miss_pc;
        w_fill         = 1'b0;
        w_req_fc       = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept_hit) begin
                    w_ready_next = 1'b1;
                    w_instr_next = w_hit_data;
                    w_pc_next    = pc_from_if;
                end else if (w_accept_miss) begin
                    w_miss_pc_next = pc_from_if;
                    w_state_next   = REQ;
                end
            end
            REQ: begin
                // A flushed request is never presented; fc drops it anyway.
                if (is_exception_from_rob) begin
                    w_state_next = IDLE;
                end else if (!is_stall_from_fc) begin
                    w_req_fc     = 1'b1;
                    w_state_next = WAIT;
                end
            end
            WAIT: begin
                // Exception has priority over a same-cycle completion.
                if (is_exception_from_rob) begin
                    w_state_next = IDLE;
                end else if (is_finish_from_fc && is_instr_from_fc) begin
                    w_fill       = 1'b1;
                    w_ready_next = 1'b1;
                    w_instr_next = data_from_fc;
                    w_pc_next    = r_miss_pc;
                    w_state_next = IDLE;
                end
            end
            default: begin
                w_state_next = IDLE;
            end
        endcase
    end

    assign is_busy_to_if  = (r_state != IDLE);
    assign is_ready_to_if = r_ready;
    assign instr_to_if    = r_instr;
    assign pc_to_if       = r_pc;
    assign is_empty_to_fc = !w_req_fc;
    assign addr_to_fc     = {r_miss_pc[ADDR_WIDTH-1:2], 2'b00};

`ifdef ICACHE_PERF_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_accept_hit && (r_hit_cnt != 32'hFFFF_FFFF)) begin
                r_hit_cnt <= r_hit_cnt + 32'd1;
            end
            if (w_accept_miss && (r_miss_cnt != 32'hFFFF_FFFF)) begin
                r_miss_cnt <= r_miss_cnt + 32'd1;
            end
        end
    end

    assign hit_cnt_out  = r_hit_cnt;
    assign miss_cnt_out = r_miss_cnt;
`else
    // Performance counters are not built in this configuration.
`endif

endmodule : icache
`default_nettype wire

// File: tb/tb_icache.sv
`default_nettype none
// ============================================================================
// Module      : tb_icache
// Description : Directed self-checking bench for icache. Inputs are driven
//               1 ns after the rising edge; outputs are compared at the same
//               point, well away from the next active edge.
// Options     : ICACHE_PERF_EN enables the hit/miss counter comparisons.
// Revision    : 1.0  initial release
// ============================================================================
module tb_icache;

    logic        clk = 1'b0;
    logic        rst;
    logic        is_req_from_if;
    logic [31:0] pc_from_if;
    logic        is_busy_to_if;
    logic        is_ready_to_if;
    logic [31:0] instr_to_if;
    logic [31:0] pc_to_if;
    logic        is_empty_to_fc;
    logic [31:0] addr_to_fc;
    logic        is_stall_from_fc;
    logic        is_finish_from_fc;
    logic        is_instr_from_fc;
    logic [31:0] data_from_fc;
    logic        is_exception_from_rob;
`ifdef ICACHE_PERF_EN
    logic [31:0] hit_cnt_out;
    logic [31:0] miss_cnt_out;
`endif

    int n_vec  = 0;
    int n_miss = 0;

    icache dut (
        .clk                   (clk),
        .rst                   (rst),
        .is_req_from_if        (is_req_from_if),
        .pc_from_if            (pc_from_if),
        .is_busy_to_if         (is_busy_to_if),
        .is_ready_to_if        (is_ready_to_if),
        .instr_to_if           (instr_to_if),
        .pc_to_if              (pc_to_if),
        .is_empty_to_fc        (is_empty_to_fc),
        .addr_to_fc            (addr_to_fc),
        .is_stall_from_fc      (is_stall_from_fc),
        .is_finish_from_fc     (is_finish_from_fc),
        .is_instr_from_fc      (is_instr_from_fc),
        .data_from_fc          (data_from_fc),
`ifdef ICACHE_PERF_EN
        .hit_cnt_out           (hit_cnt_out),
        .miss_cnt_out          (miss_cnt_out),
`endif
        .is_exception_from_rob (is_exception_from_rob)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_miss++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst                   = 1'b0;
        is_req_from_if        = 1'b0;
        pc_from_if            = 32'h0;
        is_stall_from_fc      = 1'b0;
        is_finish_from_fc     = 1'b0;
        is_instr_from_fc      = 1'b0;
        data_from_fc          = 32'h0;
        is_exception_from_rob = 1'b0;
        step();
        step();

        // Reset values
        chk("rst_busy",  {31'd0, is_busy_to_if},  32'd0);
        chk("rst_ready", {31'd0, is_ready_to_if}, 32'd0);
        chk("rst_empty", {31'd0, is_empty_to_fc}, 32'd1);
        chk("rst_instr", instr_to_if, 32'h0);
        chk("rst_pc",    pc_to_if,    32'h0);
        chk("rst_addr",  addr_to_fc,  32'h0);
        rst = 1'b1;
        step();

        // Cold miss on 0x100
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0100;
        step();
        is_req_from_if = 1'b0;
        chk("m1_busy",  {31'd0, is_busy_to_if},  32'd1);
        chk("m1_ready", {31'd0, is_ready_to_if}, 32'd0);
        chk("m1_empty", {31'd0, is_empty_to_fc}, 32'd0);
        chk("m1_addr",  addr_to_fc, 32'h0000_0100);
        step();
        chk("m1_wait_empty", {31'd0, is_empty_to_fc}, 32'd1);
        chk("m1_wait_busy",  {31'd0, is_busy_to_if},  32'd1);
        is_finish_from_fc = 1'b1; is_instr_from_fc = 1'b1; data_from_fc = 32'h0000_0013;
        step();
        is_finish_from_fc = 1'b0; is_instr_from_fc = 1'b0;
        chk("m1_ready", {31'd0, is_ready_to_if}, 32'd1);
        chk("m1_instr", instr_to_if, 32'h0000_0013);
        chk("m1_pc",    pc_to_if,    32'h0000_0100);
        chk("m1_idle",  {31'd0, is_busy_to_if}, 32'd0);

        // Hit on 0x100
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0100;
        chk("h1_noreq", {31'd0, is_empty_to_fc}, 32'd1);
        step();
        is_req_from_if = 1'b0;
        chk("h1_ready", {31'd0, is_ready_to_if}, 32'd1);
        chk("h1_instr", instr_to_if, 32'h0000_0013);
        chk("h1_busy",  {31'd0, is_busy_to_if}, 32'd0);
        chk("h1_empty", {31'd0, is_empty_to_fc}, 32'd1);
        step();
        chk("h1_pulse", {31'd0, is_ready_to_if}, 32'd0);

        // Alias 0x200 (same index, different tag)
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0200;
        step();
        is_req_from_if = 1'b0;
        chk("al_busy", {31'd0, is_busy_to_if}, 32'd1);
        chk("al_addr", addr_to_fc, 32'h0000_0200);
        chk("al_empty", {31'd0, is_empty_to_fc}, 32'd0);
        step();
        is_finish_from_fc = 1'b1; is_instr_from_fc = 1'b1; data_from_fc = 32'hDEAD_BEEF;
        step();
        is_finish_from_fc = 1'b0; is_instr_from_fc = 1'b0;
        chk("al_ready", {31'd0, is_ready_to_if}, 32'd1);
        chk("al_instr", instr_to_if, 32'hDEAD_BEEF);
        chk("al_pc",    pc_to_if,    32'h0000_0200);

        // 0x100 evicted -> miss; exception in WAIT aborts it
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0100;
        step();
        is_req_from_if = 1'b0;
        chk("ev_busy",  {31'd0, is_busy_to_if},  32'd1);
        chk("ev_ready", {31'd0, is_ready_to_if}, 32'd0);
        step();
        is_exception_from_rob = 1'b1;
        step();
        is_exception_from_rob = 1'b0;
        chk("ex_busy",  {31'd0, is_busy_to_if},  32'd0);
        chk("ex_ready", {31'd0, is_ready_to_if}, 32'd0);
        is_finish_from_fc = 1'b1; is_instr_from_fc = 1'b1; data_from_fc = 32'h0000_1234;
        step();
        is_finish_from_fc = 1'b0; is_instr_from_fc = 1'b0;
        chk("late_ready", {31'd0, is_ready_to_if}, 32'd0);
        chk("late_busy",  {31'd0, is_busy_to_if},  32'd0);

        // 0x100 still not filled -> miss; load completion ignored
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0100;
        step();
        is_req_from_if = 1'b0;
        chk("nf_busy", {31'd0, is_busy_to_if}, 32'd1);
        step();
        is_finish_from_fc = 1'b1; is_instr_from_fc = 1'b0; data_from_fc = 32'h0000_0BAD;
        step();
        chk("ld_ready", {31'd0, is_ready_to_if}, 32'd0);
        chk("ld_busy",  {31'd0, is_busy_to_if},  32'd1);
        is_instr_from_fc = 1'b1; data_from_fc = 32'h0000_0093;
        step();
        is_finish_from_fc = 1'b0; is_instr_from_fc = 1'b0;
        chk("ld_fill_ready", {31'd0, is_ready_to_if}, 32'd1);
        chk("ld_fill_instr", instr_to_if, 32'h0000_0093);
        chk("ld_fill_pc",    pc_to_if,    32'h0000_0100);

        // Stalled miss on 0x304
        is_stall_from_fc = 1'b1;
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0304;
        step();
        is_req_from_if = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("st_empty", {31'd0, is_empty_to_fc}, 32'd1);
            chk("st_busy",  {31'd0, is_busy_to_if},  32'd1);
            if (i < 4) step();
        end
        is_stall_from_fc = 1'b0;
        #1;
        chk("st_go_empty", {31'd0, is_empty_to_fc}, 32'd0);
        chk("st_go_addr",  addr_to_fc, 32'h0000_0304);
        step();
        chk("st_wait_empty", {31'd0, is_empty_to_fc}, 32'd1);
        // Request held during the returning cycle must not be accepted there
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0100;
        is_finish_from_fc = 1'b1; is_instr_from_fc = 1'b1; data_from_fc = 32'h0000_CAFE;
        step();
        is_finish_from_fc = 1'b0; is_instr_from_fc = 1'b0;
        chk("st_ready", {31'd0, is_ready_to_if}, 32'd1);
        chk("st_instr", instr_to_if, 32'h0000_CAFE);
        chk("st_pc",    pc_to_if,    32'h0000_0304);
        step();
        is_req_from_if = 1'b0;
        chk("h2_ready", {31'd0, is_ready_to_if}, 32'd1);
        chk("h2_instr", instr_to_if, 32'h0000_0093);
        chk("h2_pc",    pc_to_if,    32'h0000_0100);

        // Exception in IDLE cancels a hit
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0304; is_exception_from_rob = 1'b1;
        step();
        is_req_from_if = 1'b0; is_exception_from_rob = 1'b0;
        chk("exh_ready", {31'd0, is_ready_to_if}, 32'd0);
        chk("exh_busy",  {31'd0, is_busy_to_if},  32'd0);

        // Exception in REQ aborts the miss on 0x500
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0500;
        step();
        is_req_from_if = 1'b0;
        chk("exr_busy", {31'd0, is_busy_to_if}, 32'd1);
        is_exception_from_rob = 1'b1;
        step();
        is_exception_from_rob = 1'b0;
        chk("exr_idle",  {31'd0, is_busy_to_if},  32'd0);
        chk("exr_ready", {31'd0, is_ready_to_if}, 32'd0);

        // Line 0x304 survives exceptions: hit
        is_req_from_if = 1'b1; pc_from_if = 32'h0000_0304;
        step();
        is_req_from_if = 1'b0;
        chk("h3_ready", {31'd0, is_ready_to_if}, 32'd1);
        chk("h3_instr", instr_to_if, 32'h0000_CAFE);

`ifdef ICACHE_PERF_EN
        // Misses: 0x100, 0x200, 0x100, 0x100, 0x304, 0x500 ; hits: 0x100, 0x100, 0x304
        chk("perf_miss", miss_cnt_out, 32'd6);
        chk("perf_hit",  hit_cnt_out,  32'd3);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule : tb_icache
`default_nettype wire
